// File: rtl/mdu_e.sv
// mdu_e - execute-stage multiply/divide unit.
//
// Accepts an MDU instruction from the ID/EX register, computes the 64-bit
// product or the quotient/remainder right away, then holds it as a pending
// result while a busy counter models the multi-cycle MULT/DIV latency. The
// architectural HI/LO registers take the pending result on the edge where
// busy falls. MTHI/MTLO write HI/LO directly on the next edge.
//
// Ports:
//   clk    in   pipeline clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   MDU instruction valid in EX this cycle
//   op     in   [2:0] 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   A      in   [31:0] rs operand
//   B      in   [31:0] rt operand
//   busy   out  multi-cycle operation in flight (registered)
//   hi     out  [31:0] architectural HI
//   lo     out  [31:0] architectural LO
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        load, done;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_wr;
  logic [63:0] res;
  logic        res_wr;

  // Signed 32x32 -> 64 product.
  function automatic logic signed [63:0] smul(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    logic signed [63:0] a64, b64;
    a64 = {{32{a[31]}}, a};
    b64 = {{32{b[31]}}, b};
    return a64 * b64;
  endfunction

  // Unsigned 32x32 -> 64 product.
  function automatic logic [63:0] umul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] a64, b64;
    a64 = {32'd0, a};
    b64 = {32'd0, b};
    return a64 * b64;
  endfunction

  // Signed divide, returns {remainder, quotient}. Truncates toward zero and the
  // remainder follows the dividend. The one overflowing case (-2^31 / -1) is
  // pinned to quotient -2^31, remainder 0. A zero divisor yields zeros; the
  // caller suppresses the writeback in that case anyway.
  function automatic logic [63:0] sdivmod(input logic signed [31:0] n,
                                          input logic signed [31:0] d);
    logic signed [31:0] q, r;
    if (n == 32'sh8000_0000 && d == -32'sd1) begin
      q = n;
      r = 32'sd0;
    end else if (d == 32'sd0) begin
      q = 32'sd0;
      r = 32'sd0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  // Unsigned divide, returns {remainder, quotient}.
  function automatic logic [63:0] udivmod(input logic [31:0] n, input logic [31:0] d);
    logic [31:0] q, r;
    if (d == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  // Result for the instruction currently presented; only captured on accept.
  always_comb begin
    res    = 64'd0;
    res_wr = 1'b0;
    case (op)
      3'd0: begin res = smul(A, B);    res_wr = 1'b1;        end
      3'd1: begin res = umul(A, B);    res_wr = 1'b1;        end
      3'd2: begin res = sdivmod(A, B); res_wr = (B != 32'd0); end
      3'd3: begin res = udivmod(A, B); res_wr = (B != 32'd0); end
      default: begin res = 64'd0;      res_wr = 1'b0;        end
    endcase
  end

  // Next-state logic. Any start while in RUN is deliberately ignored.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !op[2]) begin
          state_n = RUN;
          cnt_n   = op[1] ? DIV_N : MULT_N;
          load    = 1'b1;
        end
      end
      RUN: begin
        // Counter loaded with N at accept reaches 1 on the edge N-1 later,
        // so the writeback edge is the Nth after accept.
        if (cnt == 4'd1) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
          done    = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= (state_n == RUN);
      if (load) begin
        pend_hi <= res[63:32];
        pend_lo <= res[31:0];
        pend_wr <= res_wr;
      end
      // done only occurs in RUN, so it never collides with MTHI/MTLO.
      if (done) begin
        if (pend_wr) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
        pend_wr <= 1'b0;
      end else if (state == IDLE && start && op == 3'd4) begin
        hi <= A;
      end else if (state == IDLE && start && op == 3'd5) begin
        lo <= A;
      end
    end
  end

endmodule

// File: tb/tb_mdu_e.sv
// tb_mdu_e - self-checking bench for mdu_e: a vector table of MULT/DIV
// operations plus hand-written sequences for MTHI/MTLO, divide by zero,
// start-while-busy, back-to-back issue and asynchronous reset.
module tb_mdu_e;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk;
  int n_fail;

  mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one instruction for exactly one rising edge. Returns at the
  // falling edge just after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd7;
    A     = 32'd0;
    B     = 32'd0;
  endtask

  // Called right after issue(): busy must be high for n sampled cycles with
  // HI/LO unchanged, then low with HI/LO at the expected values.
  task automatic run_check(input string name, input int n,
                           input logic [31:0] old_hi, input logic [31:0] old_lo,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    for (int j = 0; j < n; j++) begin
      chk({name, " busy"}, 32'(busy), 32'd1);
      chk({name, " hi held"}, hi, old_hi);
      chk({name, " lo held"}, lo, old_lo);
      @(negedge clk);
    end
    chk({name, " busy done"}, 32'(busy), 32'd0);
    chk({name, " hi"}, hi, exp_hi);
    chk({name, " lo"}, lo, exp_lo);
  endtask

  initial begin
    logic [31:0] cur_hi, cur_lo;
    n_chk  = 0;
    n_fail = 0;

    vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult -1*2"};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'h0000_0001, 32'hFFFF_FFFE, "multu"};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"};
    vecs[3] = '{3'd3, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003, "divu 7/2"};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, "div ovf"};
    vecs[5] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, "div 7/-2"};
    vecs[6] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000, "mult min*min"};

    rst   = 1'b1;
    start = 1'b0;
    op    = 3'd7;
    A     = 32'd0;
    B     = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven MULT/DIV vectors.
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      run_check(vecs[i].name, vecs[i].n, cur_hi, cur_lo, vecs[i].exp_hi, vecs[i].exp_lo);
      cur_hi = vecs[i].exp_hi;
      cur_lo = vecs[i].exp_lo;
    end

    // No-op must not disturb anything.
    issue(3'd6, 32'hDEAD_BEEF, 32'h1);
    chk("nop busy", 32'(busy), 32'd0);
    chk("nop hi", hi, cur_hi);
    chk("nop lo", lo, cur_lo);

    // MTHI then MTLO, each visible one edge later, no busy.
    issue(3'd4, 32'h0000_0011, 32'd0);
    chk("mthi busy", 32'(busy), 32'd0);
    chk("mthi hi", hi, 32'h0000_0011);
    chk("mthi lo untouched", lo, cur_lo);
    issue(3'd5, 32'h0000_0022, 32'd0);
    chk("mtlo busy", 32'(busy), 32'd0);
    chk("mtlo hi untouched", hi, 32'h0000_0011);
    chk("mtlo lo", lo, 32'h0000_0022);

    // Divide by zero: full latency, HI/LO unchanged.
    issue(3'd3, 32'h0000_0064, 32'd0);
    run_check("divu by 0", 10, 32'h11, 32'h22, 32'h11, 32'h22);
    issue(3'd2, 32'hFFFF_FF00, 32'd0);
    run_check("div by 0", 10, 32'h11, 32'h22, 32'h11, 32'h22);

    // Start while busy is ignored.
    issue(3'd0, 32'd3, 32'd4);
    chk("mult3x4 busy c0", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b1;
    op    = 3'd3;
    A     = 32'd9;
    B     = 32'd2;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd7;
    A     = 32'd0;
    B     = 32'd0;
    run_check("mult3x4 ignore", 3, 32'h11, 32'h22, 32'd0, 32'd12);

    // Back-to-back: next op accepted right after busy falls.
    issue(3'd1, 32'd5, 32'd6);
    run_check("multu b2b", 5, 32'd0, 32'd12, 32'd0, 32'd30);

    // Asynchronous reset in the middle of a DIVU.
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    chk("pre-rst busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst hi", hi, 32'd0);
    chk("async rst lo", lo, 32'd0);
    #1;
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("post-rst busy", 32'(busy), 32'd0);
      chk("post-rst hi", hi, 32'd0);
      chk("post-rst lo", lo, 32'd0);
    end

    // Unit still works after reset.
    issue(3'd3, 32'd100, 32'd7);
    run_check("divu after rst", 10, 32'd0, 32'd0, 32'd2, 32'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
